// File: rtl/input_debouncer_pkg.sv
// input_debouncer_pkg: shared defaults and counter-width helper for the debouncer.
package debounce_pkg;
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int NCH_DEF = 2;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/input_debouncer_if.sv
// input_debouncer_if: enable, raw pin levels and conditioned outputs of the debouncer.
interface input_debouncer_if #(parameter int NCH = 2);
  logic           en;
  logic [NCH-1:0] raw_in;
  logic [NCH-1:0] clean;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] fall;
  modport master (output en, raw_in, input clean, rise, fall);
  modport slave (input en, raw_in, output clean, rise, fall);
endinterface

// File: rtl/input_debouncer_ch.sv
// debounce_ch: one channel -- 2-flop synchronizer, hold counter, clean level and edge pulses.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);
  localparam int CNT_W = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic             r_s1, r_s2, r_clean, r_rise, r_fall;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff, w_accept;
  assign w_diff   = r_s2 != r_clean;
  assign w_accept = en && w_diff && r_cnt == TERM;
  // counter clears on agreement or acceptance, so it never wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_cnt   <= '0;
      r_clean <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_s1    <= raw;
      r_s2    <= r_s1;
      r_rise  <= w_accept && r_s2;
      r_fall  <= w_accept && !r_s2;
      r_clean <= w_accept ? r_s2 : r_clean;
      r_cnt   <= !en ? r_cnt : (!w_diff || w_accept) ? '0 : r_cnt + 1'b1;
    end
  end
  assign clean = r_clean;
  assign rise  = r_rise;
  assign fall  = r_fall;
endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: NCH independent debounce channels feeding the AND cell operands.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input logic clk,
  input logic rst,
  input_debouncer_if.slave bus
);
  logic [NCH-1:0] w_clean, w_rise, w_fall;
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_cycles
    $error("input_debouncer: DEBOUNCE_CYCLES must be 1..255");
  end
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
      .clk   (clk),
      .rst   (rst),
      .en    (bus.en),
      .raw   (bus.raw_in[c]),
      .clean (w_clean[c]),
      .rise  (w_rise[c]),
      .fall  (w_fall[c])
    );
  end
  assign bus.clean = w_clean;
  assign bus.rise  = w_rise;
  assign bus.fall  = w_fall;
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed vectors with hand-computed expectations, DEBOUNCE_CYCLES = 4.
module tb_input_debouncer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  input_debouncer_if #(.NCH(2)) bus ();
  input_debouncer #(.NCH(2), .DEBOUNCE_CYCLES(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {bus.clean, bus.rise, bus.fall};
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s clean/rise/fall observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  initial begin
    logic [10:0] seq;
    bus.en = 1'b1;
    bus.raw_in = 2'b11;
    step(3);
    chk("reset_hold", 6'b00_00_00);
    rst = 1'b0;
    step(5);
    chk("rise_edge5", 6'b00_00_00);
    step(1);
    chk("rise_edge6", 6'b11_11_00);
    step(1);
    chk("rise_clear", 6'b11_00_00);
    bus.raw_in = 2'b10;
    step(5);
    chk("fall0_edge5", 6'b11_00_00);
    step(1);
    chk("fall0_edge6", 6'b10_00_01);
    step(1);
    chk("fall0_clear", 6'b10_00_00);
    bus.raw_in = 2'b00;
    step(6);
    chk("fall1_edge6", 6'b00_00_10);
    step(1);
    chk("fall1_clear", 6'b00_00_00);
    bus.raw_in = 2'b01;
    step(3);
    bus.raw_in = 2'b00;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk($sformatf("glitch_%0d", i), 6'b00_00_00);
    end
    seq = 11'b111_1111_1011;
    for (int e = 1; e <= 11; e++) begin
      bus.raw_in = {seq[e-1], 1'b0};
      step(1);
      chk($sformatf("bounce_e%0d", e), e >= 9 ? (e == 9 ? 6'b10_10_00 : 6'b10_00_00) : 6'b00_00_00);
    end
    bus.raw_in = 2'b11;
    step(4);
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk($sformatf("freeze_%0d", i), 6'b10_00_00);
    end
    bus.en = 1'b1;
    step(1);
    chk("resume_1", 6'b10_00_00);
    step(1);
    chk("resume_2", 6'b11_01_00);
    step(1);
    chk("resume_clear", 6'b11_00_00);
    bus.raw_in = 2'b01;
    step(6);
    chk("prep_fall1", 6'b01_00_10);
    bus.raw_in = 2'b11;
    step(4);
    chk("midcount", 6'b01_00_00);
    #3 rst = 1'b1;
    #1;
    chk("async_rst", 6'b00_00_00);
    step(2);
    chk("rst_no_fall", 6'b00_00_00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
